alu: RTL and testbench
======================

# alu

Registered 32-bit integer ALU for the RISC datapath. Takes two 32-bit operands and a 5-bit operation code, computes one of twelve arithmetic, logic, shift, multiply or divide operations, and presents a 64-bit result one clock after the operands are sampled. The upper result word feeds the HI register: high product or remainder. The lower word feeds the LO/Z path.

## Interface
- No parameters. Data width is fixed at 32-bit operands and a 64-bit result.
- clock  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset, sampled on rising edge of clock.
- input_a  input  32  operand A: minuend, dividend, multiplicand, shift/rotate source.
- input_b  input  32  operand B: subtrahend, divisor, multiplier, shift amount in bits [4:0].
- opcode  input  5  operation select.
- ALU_result  output  64  registered result; [63:32] = HI word, [31:0] = LO word.

## Operation
- Opcodes (unlisted codes 12–31 produce 0):
  - 0 ADD: A+B, modulo 2^32.
  - 1 SUB: A−B, modulo 2^32.
  - 2 AND: A&B.
  - 3 OR: A|B.
  - 4 SHR: logical right shift of A by B[4:0].
  - 5 SHRA: arithmetic right shift of A by B[4:0]; sign-fill.
  - 6 SHL: left shift of A by B[4:0].
  - 7 ROR: rotate A right by B[4:0].
  - 8 ROL: rotate A left by B[4:0].
  - 9 NEG: −A, two's complement; B ignored.
  - 10 MUL: signed 32×32 → full 64-bit signed product across [63:0].
  - 11 DIV: signed division.
    - LO = quotient, truncated toward zero.
    - HI = remainder, carrying the sign of the dividend.
- Ops 0–9: result in LO; HI = 0. No sign extension into HI.
- Shift/rotate amount 0: A unchanged. Only B[4:0] is used; B[31:5] ignored.
- Overflow in ADD/SUB/NEG wraps silently; no flags output.
- NEG of 0x80000000 = 0x80000000.
- DIV by zero: LO = 0xFFFFFFFF, HI = A. No exception.
- DIV 0x80000000 / −1: LO = 0x80000000, HI = 0.
- Operands are interpreted as two's complement only for SHRA, MUL and DIV.

## Timing
- Single pipeline stage: operands and opcode sampled at rising edge N; ALU_result valid after edge N and held until edge N+1.
- Latency 1 cycle; throughput one operation per cycle for every opcode, including MUL and DIV. Combinational multiplier/divider.
- No handshake; a new operation is accepted every cycle.
- clear = 1 at a rising edge: ALU_result = 64'h0 after that edge, regardless of inputs.
- clear takes priority over computation.
- First valid result: edge after clear deasserts.
- Clear asserted mid-stream discards the in-flight result.
- No combinational path from inputs to ALU_result.
- Inputs changing between edges have no effect until the next edge.

## Test plan
- Reset: clear=1 for 2 cycles with A=2, B=3, op=0 -> ALU_result = 0. Release clear -> next edge 64'h0000_0000_0000_0005.
- Arithmetic/logic:
  - A=2, B=3: op1 -> LO = 0xFFFFFFFF, HI = 0.
  - A=12, B=17: op2 -> 0x0.
  - A=17, B=20: op3 -> 0x15.
- Shifts/rotates, A=17, B=17:
  - op4 -> 0.
  - op5 with A=0x80000000 -> 0xFFFFC000.
  - op6 -> 0x00220000.
  - op7 -> 0x00088000.
  - op8 -> 0x00220000.
  - op9 -> 0xFFFFFFEF.
- MUL (op10):
  - 17×17 -> 0x121.
  - −6×5 -> 0xFFFFFFFF_FFFFFFE2.
  - −17×−9 -> 0x99.
  - 8×24 -> 0xC0.
  - 0x80000000×0x80000000 -> 0x40000000_00000000.
- DIV (op11):
  - −8/−3 -> LO = 2, HI = 0xFFFFFFFE.
  - 7/−2 -> LO = 0xFFFFFFFD, HI = 1.
  - 5/0 -> LO = 0xFFFFFFFF, HI = 5.
- Back-to-back: change opcode every cycle across 0..11 -> each result appears exactly one edge after its operands; opcode 13 -> 0.

Source files
------------

// File: rtl/alu.sv
// alu -- registered 32-bit integer ALU for the RISC datapath.
//
// One result per clock for every opcode: the multiplier and divider are fully
// combinational, and the only state is the 64-bit result register.
//
// Ports:
//   clock       in   1   system clock, rising edge
//   clear       in   1   synchronous active-high reset (wins over compute)
//   input_a     in  32   operand A (minuend, dividend, multiplicand, shift source)
//   input_b     in  32   operand B (subtrahend, divisor, multiplier, shift amount [4:0])
//   opcode      in   5   operation select, codes 12..31 yield zero
//   ALU_result  out 64   registered result, [63:32] = HI, [31:0] = LO
module alu (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic [4:0]  opcode,
  output logic [63:0] ALU_result
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SHR  = 5'd4,
    OP_SHRA = 5'd5,
    OP_SHL  = 5'd6,
    OP_ROR  = 5'd7,
    OP_ROL  = 5'd8,
    OP_NEG  = 5'd9,
    OP_MUL  = 5'd10,
    OP_DIV  = 5'd11
  } op_e;

  logic [63:0] result_q, result_d;

  logic [4:0]         shamt;
  logic [5:0]         shamt_inv;   // 32 - shamt; a shift by 32 yields 0, so shamt=0 rotates cleanly
  logic signed [31:0] sa, sb, sb_safe;
  logic signed [63:0] a_ext, b_ext, product;
  logic signed [31:0] quot, rem;
  logic               div_zero, div_ovf;

  always_comb begin
    shamt     = input_b[4:0];
    shamt_inv = 6'd32 - {1'b0, shamt};
    sa        = $signed(input_a);
    sb        = $signed(input_b);

    // Sign-extend to 64 bits so the truncated 64-bit product is the full signed result.
    a_ext   = {{32{input_a[31]}}, input_a};
    b_ext   = {{32{input_b[31]}}, input_b};
    product = a_ext * b_ext;

    // Special divide cases are resolved explicitly; the divider itself only ever
    // sees a safe divisor so it never evaluates x/0 or MIN/-1.
    div_zero = (input_b == 32'h0);
    div_ovf  = (input_a == 32'h8000_0000) && (input_b == 32'hFFFF_FFFF);
    sb_safe  = (div_zero || div_ovf) ? 32'sd1 : sb;
    quot     = sa / sb_safe;
    rem      = sa % sb_safe;

    result_d = 64'h0;
    case (opcode)
      OP_ADD:  result_d[31:0] = input_a + input_b;
      OP_SUB:  result_d[31:0] = input_a - input_b;
      OP_AND:  result_d[31:0] = input_a & input_b;
      OP_OR:   result_d[31:0] = input_a | input_b;
      OP_SHR:  result_d[31:0] = input_a >> shamt;
      OP_SHRA: result_d[31:0] = sa >>> shamt;
      OP_SHL:  result_d[31:0] = input_a << shamt;
      OP_ROR:  result_d[31:0] = (input_a >> shamt) | (input_a << shamt_inv);
      OP_ROL:  result_d[31:0] = (input_a << shamt) | (input_a >> shamt_inv);
      OP_NEG:  result_d[31:0] = 32'h0 - input_a;
      OP_MUL:  result_d       = product;
      OP_DIV: begin
        if (div_zero)     result_d = {input_a, 32'hFFFF_FFFF};
        else if (div_ovf) result_d = {32'h0, 32'h8000_0000};
        else              result_d = {rem, quot};
      end
      default: result_d = 64'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) result_q <= 64'h0;
    else       result_q <= result_d;
  end

  assign ALU_result = result_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu -- scoreboard bench for alu. Stimulus pushes hand-computed expected
// results into a queue; a monitor pops one per rising edge and compares, and
// also checks the output holds steady while inputs change mid-cycle.
module tb_alu;

  logic        clock;
  logic        clear;
  logic [31:0] input_a, input_b;
  logic [4:0]  opcode;
  logic [63:0] ALU_result;

  typedef struct {
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   done   = 0;

  alu dut (
    .clock      (clock),
    .clear      (clear),
    .input_a    (input_a),
    .input_b    (input_b),
    .opcode     (opcode),
    .ALU_result (ALU_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one operation at the falling edge; the DUT samples it at the next rising edge.
  task automatic issue(input logic clr, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic [63:0] exp, input string name);
    exp_t e;
    @(negedge clock);
    clear   = clr;
    input_a = a;
    input_b = b;
    opcode  = op;
    e.exp   = exp;
    e.name  = name;
    q.push_back(e);
  endtask

  // Monitor: one result per rising edge, then a hold check after inputs move.
  initial begin
    exp_t        e;
    logic [63:0] last;
    bit          have_last;
    have_last = 0;
    last      = 64'h0;
    while (!done) begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ALU_result !== e.exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", e.name, ALU_result, e.exp);
        end
        last      = e.exp;
        have_last = 1;
      end
      @(negedge clock);
      #2;
      if (have_last) begin
        checks++;
        if (ALU_result !== last) begin
          fails++;
          $display("FAIL hold: got %h expected %h", ALU_result, last);
        end
      end
    end
  end

  initial begin
    int budget;
    clear   = 1'b1;
    input_a = 32'd2;
    input_b = 32'd3;
    opcode  = 5'd0;

    // Reset behaviour and first result after release.
    issue(1, 32'd2, 32'd3, 5'd0, 64'h0, "reset0");
    issue(1, 32'd2, 32'd3, 5'd0, 64'h0, "reset1");
    issue(0, 32'd2, 32'd3, 5'd0, 64'h5, "add_after_reset");

    // Arithmetic / logic.
    issue(0, 32'd2,  32'd3,  5'd1, 64'h0000_0000_FFFF_FFFF, "sub");
    issue(0, 32'd12, 32'd17, 5'd2, 64'h0, "and");
    issue(0, 32'd17, 32'd20, 5'd3, 64'h15, "or");
    issue(0, 32'hFFFF_FFFF, 32'd1, 5'd0, 64'h0, "add_wrap");

    // Shifts / rotates.
    issue(0, 32'd17,        32'd17, 5'd4, 64'h0, "shr");
    issue(0, 32'h8000_0000, 32'd17, 5'd5, 64'h0000_0000_FFFF_C000, "shra_neg");
    issue(0, 32'd17,        32'd17, 5'd6, 64'h0022_0000, "shl");
    issue(0, 32'd17,        32'd17, 5'd7, 64'h0008_8000, "ror");
    issue(0, 32'd17,        32'd17, 5'd8, 64'h0022_0000, "rol");
    issue(0, 32'd17,        32'd17, 5'd9, 64'h0000_0000_FFFF_FFEF, "neg");
    issue(0, 32'h8000_0000, 32'd0,  5'd9, 64'h0000_0000_8000_0000, "neg_min");
    issue(0, 32'h0000_1234, 32'h20, 5'd6, 64'h1234, "shl_amt0_hi_ignored");
    issue(0, 32'h8000_0001, 32'h40, 5'd7, 64'h8000_0001, "ror_amt0");
    issue(0, 32'h8000_0001, 32'd1,  5'd8, 64'h3, "rol_wrap");

    // Multiply.
    issue(0, 32'd17,        32'd17,        5'd10, 64'h121, "mul_17x17");
    issue(0, 32'hFFFF_FFFA, 32'd5,         5'd10, 64'hFFFF_FFFF_FFFF_FFE2, "mul_neg6x5");
    issue(0, 32'hFFFF_FFEF, 32'hFFFF_FFF7, 5'd10, 64'h99, "mul_neg17xneg9");
    issue(0, 32'd8,         32'd24,        5'd10, 64'hC0, "mul_8x24");
    issue(0, 32'h8000_0000, 32'h8000_0000, 5'd10, 64'h4000_0000_0000_0000, "mul_minxmin");

    // Divide.
    issue(0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd11, 64'hFFFF_FFFE_0000_0002, "div_neg8_neg3");
    issue(0, 32'd7,         32'hFFFF_FFFE, 5'd11, 64'h0000_0001_FFFF_FFFD, "div_7_neg2");
    issue(0, 32'd5,         32'd0,         5'd11, 64'h0000_0005_FFFF_FFFF, "div_5_0");
    issue(0, 32'hFFFF_FFFB, 32'd0,         5'd11, 64'hFFFF_FFFB_FFFF_FFFF, "div_neg5_0");
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 64'h0000_0000_8000_0000, "div_min_neg1");

    // Back-to-back sweep, A=B=17.
    issue(0, 32'd17, 32'd17, 5'd0,  64'h22, "b2b_add");
    issue(0, 32'd17, 32'd17, 5'd1,  64'h0, "b2b_sub");
    issue(0, 32'd17, 32'd17, 5'd2,  64'h11, "b2b_and");
    issue(0, 32'd17, 32'd17, 5'd3,  64'h11, "b2b_or");
    issue(0, 32'd17, 32'd17, 5'd4,  64'h0, "b2b_shr");
    issue(0, 32'd17, 32'd17, 5'd5,  64'h0, "b2b_shra");
    issue(0, 32'd17, 32'd17, 5'd6,  64'h0022_0000, "b2b_shl");
    issue(0, 32'd17, 32'd17, 5'd7,  64'h0008_8000, "b2b_ror");
    issue(0, 32'd17, 32'd17, 5'd8,  64'h0022_0000, "b2b_rol");
    issue(0, 32'd17, 32'd17, 5'd9,  64'hFFFF_FFEF, "b2b_neg");
    issue(0, 32'd17, 32'd17, 5'd10, 64'h121, "b2b_mul");
    issue(0, 32'd17, 32'd17, 5'd11, 64'h1, "b2b_div");
    issue(0, 32'd17, 32'd17, 5'd13, 64'h0, "b2b_op13");
    issue(0, 32'd17, 32'd17, 5'd31, 64'h0, "op31");

    // Clear mid-stream discards the in-flight op, then normal service resumes.
    issue(0, 32'd100, 32'd1,  5'd0, 64'h65, "pre_clear");
    issue(1, 32'd100, 32'd1,  5'd0, 64'h0, "mid_clear");
    issue(0, 32'd9,   32'd4,  5'd1, 64'h5, "post_clear");

    // Drain with a bounded wait.
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    repeat (2) @(posedge clock);
    done = 1;
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
